// File: rtl/alu_exec_stage.sv
// ALU execute stage: a small operand queue feeding one registered ALU result slot.
// Operations are accepted into the queue. The head entry is computed and loaded into
// Result/Zero whenever the output slot is empty or is being consumed, which gives one
// result per cycle under continuous flow. No path runs combinationally from the inputs
// to the outputs.
module alu_exec_stage #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic [2:0]       ALU_Control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic [15:0]      op_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpOr  = 3'd2,
    OpXor = 3'd3,
    OpNor = 3'd4,
    OpAnd = 3'd5,
    OpSrl = 3'd6,
    OpSlt = 3'd7
  } alu_op_e;

  // Queue storage (data only; validity is tracked by the pointers and the count)
  logic [WIDTH-1:0] mem_a_q  [DEPTH];
  logic [WIDTH-1:0] mem_b_q  [DEPTH];
  logic [2:0]       mem_op_q [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Cleared by reset; set on the first clock edge after reset is released
  logic             run_q, run_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [15:0]      op_count_q, op_count_d;

  logic             push;
  logic             pop;
  logic             out_free;
  logic             consume;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [2:0]       head_op;
  logic [WIDTH-1:0] alu_res;

  // Result of one ALU operation; ADD and SUB wrap modulo 2^WIDTH
  function automatic logic [WIDTH-1:0] alu_compute(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [2:0]       op);
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (alu_op_e'(op))
      OpAdd: r = a + b;
      OpSub: r = a - b;
      OpOr:  r = a | b;
      OpXor: r = a ^ b;
      OpNor: r = ~(a | b);
      OpAnd: r = a & b;
      OpSrl: r = a >> b[3:0];
      OpSlt: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Handshake qualifiers; full blocks acceptance even when a pop happens in the same edge
  always_comb begin
    in_ready = run_q && (count_q < CntW'(DEPTH));
    push     = in_valid && in_ready;
    out_free = !out_valid_q || out_ready;
    pop      = (count_q != '0) && out_free;
    consume  = out_valid_q && out_ready;
    head_a   = mem_a_q[rd_ptr_q];
    head_b   = mem_b_q[rd_ptr_q];
    head_op  = mem_op_q[rd_ptr_q];
    alu_res  = alu_compute(head_a, head_b, head_op);
  end

  // Next-state for queue pointers, occupancy, output slot and consume counter
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    run_d       = 1'b1;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    op_count_d  = op_count_q;

    // Power-of-two depth lets the pointers wrap naturally
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end

    // Load a new result when the slot frees up; otherwise drop valid once consumed
    if (pop) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
    end else if (consume) begin
      out_valid_d = 1'b0;
    end

    if (consume) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  // Control and output state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      op_count_q  <= op_count_d;
    end
  end

  // Queue data write; stale contents are harmless because the count guards reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]  <= input_A;
      mem_b_q[wr_ptr_q]  <= input_B;
      mem_op_q[wr_ptr_q] <= ALU_Control;
    end
  end

  // Drive the outputs straight from the registers
  always_comb begin
    out_valid = out_valid_q;
    Result    = result_q;
    Zero      = zero_q;
    op_count  = op_count_q;
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: expected results are queued at acceptance
// and compared in order as the DUT hands results downstream.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] input_A;
  logic [15:0] input_B;
  logic [2:0]  ALU_Control;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Result;
  logic        Zero;
  logic [15:0] op_count;

  typedef struct {
    logic [15:0] res;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   cons_cyc[$];
  int   n_checks;
  int   n_fail;
  int   cyc;

  alu_exec_stage #(
    .DEPTH(4),
    .WIDTH(16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .input_A    (input_A),
    .input_B    (input_B),
    .ALU_Control(ALU_Control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .Zero       (Zero),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU written from the opcode table
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return ~(a | b);
      3'd5: return a & b;
      3'd6: return a >> b[3:0];
      default: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
    endcase
  endfunction

  // Present one operation and hold it until accepted; expectation queued at acceptance
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                      input logic [15:0] res);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    in_valid    = 1'b1;
    input_A     = a;
    input_B     = b;
    ALU_Control = op;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check_eq("send_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      e.res  = res;
      e.zero = (res == 16'd0);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_empty", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: a result is consumed on the next rising edge when valid and ready are both high
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("result", {16'd0, Result}, {16'd0, e.res});
        check_eq("zero", {31'd0, Zero}, {31'd0, e.zero});
        cons_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] v;
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    input_A     = '0;
    input_B     = '0;
    ALU_Control = '0;
    out_ready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_result", {16'd0, Result}, 32'd0);
    check_eq("rst_zero", {31'd0, Zero}, 32'd0);
    check_eq("rst_op_count", {16'd0, op_count}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rel_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_eq("rel_in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Single ADD: valid appears after the second edge following acceptance
    out_ready = 1'b1;
    send(16'd10, 16'd20, 3'd0, 16'd30);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("lat_after_accept", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("lat_after_next", {31'd0, out_valid}, 32'd1);
    check_eq("lat_result", {16'd0, Result}, 32'd30);
    drain();

    // Back-to-back operations, one result per cycle
    cons_cyc.delete();
    send(16'd10, 16'd20, 3'd1, 16'hFFF6);
    send(16'd10, 16'd20, 3'd7, 16'd1);
    send(16'd6, 16'd2, 3'd5, 16'd2);
    send(16'd5, 16'd5, 3'd1, 16'd0);
    idle();
    drain();
    check_eq("b2b_count", cons_cyc.size(), 32'd4);
    if (cons_cyc.size() == 4) begin
      check_eq("b2b_spacing", cons_cyc[3] - cons_cyc[0], 32'd3);
    end

    // Signed compare and shift corner cases
    send(16'hFFFF, 16'd1, 3'd7, 16'd1);
    send(16'd1, 16'hFFFF, 3'd7, 16'd0);
    send(16'h8000, 16'd15, 3'd6, 16'd1);
    send(16'hFFFF, 16'd1, 3'd0, 16'd0);
    send(16'h00F0, 16'h0F0F, 3'd4, 16'hF000);
    idle();
    drain();

    // Backpressure: 4 queued plus 1 held, then full drain in order
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 16'(i * 3 + 1);
      b = 16'(i);
      send(a, b, 3'd3, a ^ b);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    check_eq("bp_out_held", {31'd0, out_valid}, 32'd1);
    check_eq("bp_result_held", {16'd0, Result}, 32'd1);
    out_ready = 1'b1;
    drain();
    check_eq("bp_op_count", {16'd0, op_count}, 32'd5);

    // Random operations with random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          a  = 16'($urandom());
          b  = 16'($urandom());
          op = 3'($urandom_range(0, 7));
          send(a, b, op, model(a, b, op));
        end
        idle();
      end
      begin
        repeat (60) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with 3 queued and a result held; nothing stale may appear afterwards
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(16'(i + 100), 16'd1, 3'd0, 16'(i + 101));
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_result", {16'd0, Result}, 32'd0);
    check_eq("arst_zero", {31'd0, Zero}, 32'd0);
    check_eq("arst_op_count", {16'd0, op_count}, 32'd0);
    check_eq("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    check_eq("post_rst_op_count", {16'd0, op_count}, 32'd0);

    // op_count wrap after 65537 consumed results
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      v = 16'(i);
      send(v, 16'd0, 3'd0, v);
    end
    idle();
    drain();
    check_eq("op_count_wrap", {16'd0, op_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
